// File: rtl/bus_slave_regs.sv
// bus_slave_regs: bus slave with three read/write registers and an access counter.
// The slave latches a request, waits a fixed number of cycles, then pulses
// rdy_ low for one cycle.
//
// Ports:
//   clk      in   system clock, rising edge
//   reset    in   synchronous reset, active high
//   cs_      in   chip select, active low
//   as_      in   address strobe, active low
//   rw       in   1 = read, 0 = write
//   addr     in   word address [29:0]; only bits [1:0] are decoded
//   wr_data  in   write data [31:0]
//   rd_data  out  read data [31:0]; zero unless a read is being acknowledged
//   rdy_     out  access-complete strobe, active low, one cycle per access
//
// state | meaning
// IDLE  | waiting for cs_ = 0 and as_ = 0; the request is latched here
// WAIT  | inserting WAIT_STATES cycles (down-counter)
// ACK   | rdy_ low for one cycle; write and count update on the closing edge
module bus_slave_regs #(
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs_,
    input  logic        as_,
    input  logic        rw,
    input  logic [29:0] addr,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic        rdy_
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_t;

    localparam logic [3:0] WS = 4'(WAIT_STATES);

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  wait_cnt;
    logic [1:0]  idx_q;
    logic        rw_q;
    logic [31:0] wdata_q;
    logic [31:0] reg0;
    logic [31:0] reg1;
    logic [31:0] reg2;
    logic [31:0] acc_cnt;
    logic        req;

    // The upper address bits alias onto the same four registers.
    logic        unused_addr_hi;
    assign unused_addr_hi = ^addr[29:2];

    assign req = !cs_ && !as_;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (req) state_nxt = (WS == 4'd0) ? ACK : WAIT;
            // Counter is loaded with WAIT_STATES on capture, so terminal count
            // at 1 gives exactly WAIT_STATES cycles in WAIT.
            WAIT: if (wait_cnt <= 4'd1) state_nxt = ACK;
            ACK:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            wait_cnt <= '0;
            idx_q    <= '0;
            rw_q     <= 1'b0;
            wdata_q  <= '0;
            reg0     <= '0;
            reg1     <= '0;
            reg2     <= '0;
            acc_cnt  <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && req) begin
                idx_q    <= addr[1:0];
                rw_q     <= rw;
                wdata_q  <= wr_data;
                wait_cnt <= WS;
            end else if (state == WAIT && wait_cnt != 4'd0) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
            if (state == ACK) begin
                acc_cnt <= acc_cnt + 32'd1;
                if (!rw_q) begin
                    case (idx_q)
                        2'd0:    reg0 <= wdata_q;
                        2'd1:    reg1 <= wdata_q;
                        2'd2:    reg2 <= wdata_q;
                        default: ;  // ACC_CNT is read-only; write is dropped
                    endcase
                end
            end
        end
    end

    // ACC_CNT reads return the pre-increment value because the increment
    // lands on the edge that ends ACK.
    always_comb begin
        rd_data = '0;
        if (state == ACK && rw_q) begin
            case (idx_q)
                2'd0:    rd_data = reg0;
                2'd1:    rd_data = reg1;
                2'd2:    rd_data = reg2;
                default: rd_data = acc_cnt;
            endcase
        end
    end

    assign rdy_ = (state != ACK);

endmodule

// File: tb/tb_bus_slave_regs.sv
module tb_bus_slave_regs;

    logic        clk;
    logic        reset;
    logic        cs_;
    logic        as_;
    logic        rw;
    logic [29:0] addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data0;
    logic [31:0] rd_data2;
    logic        rdy0_;
    logic        rdy2_;

    int checks = 0;
    int errors = 0;

    // Reference state: register contents and access count.
    logic [31:0] regs_m [3];
    logic [31:0] cnt_m;

    bus_slave_regs #(.WAIT_STATES(0)) u0 (
        .clk(clk), .reset(reset), .cs_(cs_), .as_(as_), .rw(rw),
        .addr(addr), .wr_data(wr_data), .rd_data(rd_data0), .rdy_(rdy0_)
    );

    bus_slave_regs #(.WAIT_STATES(2)) u2 (
        .clk(clk), .reset(reset), .cs_(cs_), .as_(as_), .rw(rw),
        .addr(addr), .wr_data(wr_data), .rd_data(rd_data2), .rdy_(rdy2_)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) regs_m[i] = '0;
        cnt_m = '0;
    endtask

    // Inputs that must never form a request: at least one strobe high.
    task automatic drive_garbage();
        if ($urandom_range(0, 1) == 1) begin
            cs_ = 1'b1;
            as_ = 1'($urandom_range(0, 1));
        end else begin
            cs_ = 1'b0;
            as_ = 1'b1;
        end
        rw      = 1'($urandom_range(0, 1));
        addr    = 30'($urandom);
        wr_data = $urandom;
    endtask

    task automatic check_idle(input string tag, input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk); #1;
            check({tag, " rdy0"}, {31'd0, rdy0_}, 32'd1);
            check({tag, " rdy2"}, {31'd0, rdy2_}, 32'd1);
            check({tag, " rd0"}, rd_data0, 32'd0);
            check({tag, " rd2"}, rd_data2, 32'd0);
        end
    endtask

    // One single-cycle request, then watch both slaves for WAIT_STATES+2 edges.
    // WS=0 slave acknowledges in the cycle right after the capture edge,
    // WS=2 slave two cycles later.
    task automatic access(input logic r, input logic [29:0] a, input logic [31:0] d, input string tag);
        logic [1:0]  idx;
        logic [31:0] exp_rd;
        idx = a[1:0];
        if (r) exp_rd = (idx == 2'd3) ? cnt_m : regs_m[idx];
        else   exp_rd = 32'd0;

        @(negedge clk);
        cs_ = 1'b0; as_ = 1'b0; rw = r; addr = a; wr_data = d;
        @(posedge clk);
        for (int c = 0; c < 4; c++) begin
            if (c > 0) @(posedge clk);
            #1;
            check({tag, " rdy0"}, {31'd0, rdy0_}, (c == 0) ? 32'd0 : 32'd1);
            check({tag, " rd0"},  rd_data0, (c == 0) ? exp_rd : 32'd0);
            check({tag, " rdy2"}, {31'd0, rdy2_}, (c == 2) ? 32'd0 : 32'd1);
            check({tag, " rd2"},  rd_data2, (c == 2) ? exp_rd : 32'd0);
            drive_garbage();
        end
        cs_ = 1'b1; as_ = 1'b1;

        if (!r && idx != 2'd3) regs_m[idx] = d;
        cnt_m = cnt_m + 32'd1;
    endtask

    initial begin
        reset = 1'b1; cs_ = 1'b1; as_ = 1'b1; rw = 1'b0; addr = '0; wr_data = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset rdy0", {31'd0, rdy0_}, 32'd1);
        check("reset rdy2", {31'd0, rdy2_}, 32'd1);
        check("reset rd0", rd_data0, 32'd0);
        check("reset rd2", rd_data2, 32'd0);
        @(negedge clk); reset = 1'b0;

        access(1'b1, 30'd0, 32'd0, "rst_reg0");
        access(1'b1, 30'd3, 32'd0, "rst_cnt");

        access(1'b0, 30'd1, 32'hDEAD_BEEF, "wr_reg1");
        access(1'b1, 30'd1, 32'd0, "rd_reg1");

        access(1'b0, 30'd2, 32'h1234_5678, "wr_reg2");
        access(1'b1, 30'h3FFF_FFF2, 32'd0, "rd_alias");

        access(1'b0, 30'd0, 32'hA5A5_0F0F, "wr_reg0");
        access(1'b1, 30'd3, 32'd0, "rd_cnt_a");
        access(1'b1, 30'd3, 32'd0, "rd_cnt_b");
        access(1'b0, 30'd3, 32'h0000_FFFF, "wr_cnt");
        access(1'b1, 30'd3, 32'd0, "rd_cnt_c");
        access(1'b1, 30'h0000_0004, 32'd0, "rd_reg0_alias");

        // Counter wrap
        @(negedge clk);
        force u0.acc_cnt = 32'hFFFF_FFFF;
        force u2.acc_cnt = 32'hFFFF_FFFF;
        #1;
        release u0.acc_cnt;
        release u2.acc_cnt;
        cnt_m = 32'hFFFF_FFFF;
        access(1'b1, 30'd3, 32'd0, "rd_cnt_max");
        access(1'b1, 30'd3, 32'd0, "rd_cnt_wrap");

        // Reset lands one edge after capturing a write to REG0.
        @(negedge clk);
        cs_ = 1'b0; as_ = 1'b0; rw = 1'b0; addr = 30'd0; wr_data = 32'h55;
        @(posedge clk); #1;
        cs_ = 1'b1; as_ = 1'b1;
        reset = 1'b1;
        model_reset();
        check_idle("abort", 2);
        // Request held during a reset edge must be ignored.
        @(negedge clk);
        cs_ = 1'b0; as_ = 1'b0; rw = 1'b0; addr = 30'd1; wr_data = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        cs_ = 1'b1; as_ = 1'b1;
        @(negedge clk); reset = 1'b0;
        check_idle("post_rst", 3);
        access(1'b1, 30'd0, 32'd0, "abort_reg0");
        access(1'b1, 30'd1, 32'd0, "abort_reg1");
        access(1'b1, 30'd3, 32'd0, "abort_cnt");
        access(1'b0, 30'd0, 32'h55, "after_wr0");
        access(1'b1, 30'd0, 32'd0, "after_rd0");

        for (int i = 0; i < 40; i++) begin
            access(1'($urandom_range(0, 1)), 30'($urandom), $urandom, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout observed running expected finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/bus_slave_regs.md
BUS_SLAVE_REGS -- requirements
Module: bus_slave_regs

Interface
REQ-001 SHALL provide parameter: WAIT_STATES, 2, wait cycles inserted between access capture and ready (legal 0-15).
REQ-002 SHALL provide port: clk  input  1  single system clock; all logic on rising edge.
REQ-003 SHALL provide port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL provide port: cs_  input  1  chip select from bus address decoder, active-low.
REQ-005 SHALL provide port: as_  input  1  address strobe, active-low; qualifies an access request.
REQ-006 SHALL provide port: rw  input  1  access direction; 1 = read, 0 = write.
REQ-007 SHALL provide port: addr  input  30  word address; only addr[1:0] decoded, addr[29:2] ignored (aliasing).
REQ-008 SHALL provide port: wr_data  input  32  write data.
REQ-009 SHALL provide port: rd_data  output  32  read data, valid only while rdy_ = 0.
REQ-010 SHALL provide port: rdy_  output  1  access-complete strobe, active-low, one cycle per access.

Function
REQ-011 SHALL implement FSM states IDLE, WAIT, ACK.
REQ-012 SHALL, in IDLE, start an access when cs_ = 0 and as_ = 0 on a clock edge, latching addr[1:0], rw and wr_data.
REQ-013 SHALL go IDLE -> WAIT on request if WAIT_STATES > 0, IDLE -> ACK if WAIT_STATES = 0.
REQ-014 SHALL remain in WAIT exactly WAIT_STATES cycles (down-counter loaded on capture), then enter ACK.
REQ-015 SHALL, in ACK, drive rdy_ = 0 for exactly one cycle, then return to IDLE unconditionally.
REQ-016 SHALL give request-to-rdy_ latency of WAIT_STATES + 1 cycles (request sampled edge N, rdy_ low during cycle N + WAIT_STATES + 1).
REQ-017 SHALL ignore cs_, as_, rw, addr, wr_data changes while in WAIT or ACK; latched values govern the access.
REQ-018 SHALL accept a new request no earlier than the first IDLE cycle after ACK (back-to-back: one idle cycle minimum).
REQ-019 SHALL implement register map by latched addr[1:0]: 0 REG0 RW, 1 REG1 RW, 2 REG2 RW, 3 ACC_CNT read-only.
REQ-020 SHALL perform writes on the clock edge ending the ACK cycle; writes to index 3 are discarded but still acknowledged.
REQ-021 SHALL drive rd_data with the selected register during ACK of a read; rd_data = 0 at all other times, including write ACKs.
REQ-022 SHALL increment ACC_CNT by 1 at the end of every ACK (read or write), modulo 2^32 (0xFFFFFFFF -> 0x00000000).
REQ-023 SHALL return, on a read of ACC_CNT, the value before that access's own increment.
REQ-024 SHALL treat cs_ = 0 with as_ = 1, or as_ = 0 with cs_ = 1, as no request.

Reset
REQ-025 SHALL, when reset = 1 on a clock edge, force state IDLE, wait counter 0, REG0-REG2 = 0, ACC_CNT = 0, rdy_ = 1, rd_data = 0.
REQ-026 SHALL abort any in-flight access on reset (no write, no rdy_, no count) and take priority over any simultaneous request.
REQ-027 SHALL ignore requests in the cycle reset is asserted; first request accepted on the first edge with reset = 0.

Verification
REQ-028 Write REG1 = 0xDEADBEEF, WAIT_STATES = 2 -> rdy_ low exactly 3 cycles after request for one cycle, rd_data = 0; later read of addr 1 returns 0xDEADBEEF.
REQ-029 WAIT_STATES = 0, read addr 0x3FFFFFF2 after writing REG2 = 0x12345678 -> rdy_ low 1 cycle after request, rd_data = 0x12345678 (aliasing).
REQ-030 Two writes then read of addr 3 -> rd_data = 2; a subsequent read of addr 3 -> rd_data = 3; write 0xFFFF to addr 3 has no effect on count value beyond its +1.
REQ-031 Preload ACC_CNT to 0xFFFFFFFF (via 2^32-1 accesses or force) -> one more access makes it 0x00000000.
REQ-032 Change addr/wr_data/rw and deassert cs_ during WAIT -> access completes with originally latched values, single rdy_ pulse.
REQ-033 Assert reset during WAIT of a write to REG0 = 0x55 -> no rdy_ pulse, REG0 = 0, ACC_CNT = 0, next request after reset completes normally.
